// File: rtl/riscv_if_parcel_queue_if.sv
// Signal bundle between the fetch/cache side, the parcel queue and decode.
// The pipeline drives through the master view; the queue uses the slave view.
interface riscv_if_parcel_queue_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32
);
  logic                   flush;
  logic [XLEN-1:0]        if_parcel_pc;
  logic [PARCEL_SIZE-1:0] if_parcel;
  logic [1:0]             if_parcel_valid;
  logic                   if_parcel_misaligned;
  logic                   if_stall;
  logic                   id_stall;
  logic                   id_valid;
  logic [31:0]            id_instr;
  logic [XLEN-1:0]        id_pc;
  logic                   id_rvc;
  logic                   id_misaligned;

  modport master (
    output flush, if_parcel_pc, if_parcel, if_parcel_valid, if_parcel_misaligned, id_stall,
    input  if_stall, id_valid, id_instr, id_pc, id_rvc, id_misaligned
  );

  modport slave (
    input  flush, if_parcel_pc, if_parcel, if_parcel_valid, if_parcel_misaligned, id_stall,
    output if_stall, id_valid, id_instr, id_pc, id_rvc, id_misaligned
  );
endinterface

// File: rtl/riscv_if_parcel_queue.sv
// Halfword instruction parcel queue: takes up to two halfwords per cycle from the
// cache and hands one reassembled RV32/RVC instruction per cycle to decode.
module riscv_if_parcel_queue #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_if_parcel_queue_if.slave bus
);
  localparam int          PW        = $clog2(DEPTH);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE       = (PW+1)'(1);
  localparam logic [PW:0] TWO       = (PW+1)'(2);

  logic [15:0]     mem_hw  [DEPTH];
  logic [XLEN-1:0] mem_pc  [DEPTH];
  logic            mem_err [DEPTH];

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr1;
  logic [PW-1:0]   wr_ptr1;
  logic [PW:0]     count;
  logic [PW:0]     push_num;
  logic [PW:0]     pop_num;

  logic [15:0]     wr_hw0;
  logic [15:0]     wr_hw1;
  logic [XLEN-1:0] wr_pc0;
  logic [XLEN-1:0] wr_pc1;

  logic [15:0]     head_hw;
  logic [15:0]     next_hw;
  logic [XLEN-1:0] head_pc;
  logic            head_err;
  logic            next_err;
  logic            head_is32;
  logic            need2;
  logic            avail;
  logic            if_stall_int;
  logic            id_valid_int;

  assign rd_ptr1 = rd_ptr + PW'(1);
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Throttling off registered count keeps room for a full two-halfword push.
  assign if_stall_int = (DEPTH_CNT - count) < TWO;
  assign bus.if_stall = if_stall_int;

  always_comb begin
    push_num = '0;
    if (!if_stall_int) begin
      case (bus.if_parcel_valid)
        2'b01, 2'b10: push_num = ONE;
        2'b11:        push_num = TWO;
        default:      push_num = '0;
      endcase
    end
  end

  // A lone high half takes the parcel pc, since that is where fetch resumed.
  assign wr_hw0 = bus.if_parcel_valid[0] ? bus.if_parcel[15:0] : bus.if_parcel[PARCEL_SIZE-1 -: 16];
  assign wr_pc0 = bus.if_parcel_pc;
  assign wr_hw1 = bus.if_parcel[PARCEL_SIZE-1 -: 16];
  assign wr_pc1 = bus.if_parcel_pc + XLEN'(2);

  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (push_num != '0) begin
        mem_hw[wr_ptr]  <= wr_hw0;
        mem_pc[wr_ptr]  <= wr_pc0;
        mem_err[wr_ptr] <= bus.if_parcel_misaligned;
      end
      if (push_num == TWO) begin
        mem_hw[wr_ptr1]  <= wr_hw1;
        mem_pc[wr_ptr1]  <= wr_pc1;
        mem_err[wr_ptr1] <= bus.if_parcel_misaligned;
      end
    end
  end

  assign head_hw  = mem_hw[rd_ptr];
  assign head_pc  = mem_pc[rd_ptr];
  assign head_err = mem_err[rd_ptr];
  assign next_hw  = mem_hw[rd_ptr1];
  assign next_err = mem_err[rd_ptr1];

  // A faulted head is emitted alone so decode can trap without waiting on more fetch.
  assign head_is32    = (head_hw[1:0] == 2'b11);
  assign need2        = head_is32 && !head_err;
  assign avail        = need2 ? (count >= TWO) : (count != '0);
  assign id_valid_int = avail && !bus.flush;

  always_comb begin
    pop_num = '0;
    if (id_valid_int && !bus.id_stall) begin
      pop_num = need2 ? TWO : ONE;
    end
  end

  always_comb begin
    bus.id_valid      = id_valid_int;
    bus.id_instr      = NOP;
    bus.id_pc         = '0;
    bus.id_rvc        = 1'b0;
    bus.id_misaligned = 1'b0;
    if (id_valid_int) begin
      bus.id_instr      = need2 ? {next_hw, head_hw} : {16'h0000, head_hw};
      bus.id_pc         = head_pc;
      bus.id_rvc        = !head_is32;
      bus.id_misaligned = head_err || (need2 && next_err);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + pop_num[PW-1:0];
      wr_ptr <= wr_ptr + push_num[PW-1:0];
      count  <= count + push_num - pop_num;
    end
  end
endmodule
